// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: FSM state encoding and parity-type constants shared by the UART TX arbiter
package uart_arb_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after rr_ptr
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic [ID_WIDTH-1:0] winner,
  output logic                valid
);
  // first asserted request at rr_ptr+1, rr_ptr+2, ... wraps modulo NUM_REQ
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!valid && req[(int'(rr_ptr) + i) % NUM_REQ]) begin
        valid  = 1'b1;
        winner = ID_WIDTH'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART TX among NUM_REQ byte requesters (optional UART_TX_ARB_TIMEOUT_EN)
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int FRAME_WIDTH = 8,
  parameter int ID_WIDTH    = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*FRAME_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_par_en,
  input  logic [NUM_REQ-1:0]             req_par_typ,
  output logic [NUM_REQ-1:0]             ack,
  input  logic                           tx_busy,
  output logic                           tx_data_valid,
  output logic [FRAME_WIDTH-1:0]         tx_p_data,
  output logic                           tx_par_en,
  output logic                           tx_par_typ,
  output logic [ID_WIDTH-1:0]            grant_id,
  output logic                           arb_busy,
  output logic                           err_timeout
);
  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_WIDTH) < NUM_REQ || TIMEOUT_CYC < 2) begin : g_bad_params
    $error("uart_tx_arbiter: illegal parameter combination");
  end
  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     rr_q, rr_d, gid_q, gid_d, win;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [FRAME_WIDTH-1:0]  data_q, data_d;
  logic                    dv_q, dv_d, pen_q, pen_d, ptyp_q, ptyp_d, abusy_q, abusy_d, err_q, err_d;
  logic                    win_v, grant, timeout;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_rr (
    .req(req), .rr_ptr(rr_q), .winner(win), .valid(win_v)
  );
  assign grant = state_q == IDLE && win_v && !tx_busy;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt_q, cnt_d;
  assign timeout = state_q == WAIT_BUSY && !tx_busy && cnt_q == CW'(TIMEOUT_CYC - 2);
  // restarts on entry to WAIT_BUSY; the LOAD cycle counts toward the window
  always_comb cnt_d = state_q == WAIT_BUSY ? cnt_q + 1'b1 : '0;
  // timeout counter register
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
`else
  assign timeout = 1'b0;
`endif
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= ID_WIDTH'(NUM_REQ - 1);
      gid_q   <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      pen_q   <= 1'b0;
      ptyp_q  <= PAR_EVEN;
      abusy_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      pen_q   <= pen_d;
      ptyp_q  <= ptyp_d;
      abusy_q <= abusy_d;
      err_q   <= err_d;
    end
  end
  // next-state: grant, hand off, wait for busy to rise, wait for it to fall
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      state_d = grant ? LOAD : IDLE;
      LOAD:      state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = tx_busy ? WAIT_DONE : timeout ? IDLE : WAIT_BUSY;
      WAIT_DONE: state_d = tx_busy ? WAIT_DONE : IDLE;
      default:   state_d = IDLE;
    endcase
  end
  // outputs are captured at the grant edge and held until the next grant
  always_comb begin
    ack_d   = grant ? NUM_REQ'(1) << win : '0;
    dv_d    = grant;
    data_d  = grant ? req_data[win*FRAME_WIDTH +: FRAME_WIDTH] : data_q;
    pen_d   = grant ? req_par_en[win] : pen_q;
    ptyp_d  = grant ? req_par_typ[win] : ptyp_q;
    gid_d   = grant ? win : gid_q;
    rr_d    = grant ? win : rr_q;
    abusy_d = state_d != IDLE;
    err_d   = timeout;
  end
  assign ack           = ack_q;
  assign tx_data_valid = dv_q;
  assign tx_p_data     = data_q;
  assign tx_par_en     = pen_q;
  assign tx_par_typ    = ptyp_q;
  assign grant_id      = gid_q;
  assign arb_busy      = abusy_q;
  assign err_timeout   = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed tests with a cycle-level behavioural model and literal pins
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;
  localparam int N = 4, FW = 8, IW = 2, TO = 16;
  logic clk = 0, reset = 1, tx_busy = 0;
  logic [N-1:0] req = '0, req_par_en = '0, req_par_typ = '0;
  logic [N*FW-1:0] req_data = '0;
  logic [N-1:0] ack;
  logic tx_data_valid, tx_par_en, tx_par_typ, arb_busy, err_timeout;
  logic [FW-1:0] tx_p_data;
  logic [IW-1:0] grant_id;
  int checks = 0, errors = 0;
  bit started = 0, auto_busy = 0;
  int busy_len = 10;
  uart_tx_arbiter #(.NUM_REQ(N), .FRAME_WIDTH(FW), .ID_WIDTH(IW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_par_en(req_par_en),
    .req_par_typ(req_par_typ), .ack(ack), .tx_busy(tx_busy), .tx_data_valid(tx_data_valid),
    .tx_p_data(tx_p_data), .tx_par_en(tx_par_en), .tx_par_typ(tx_par_typ), .grant_id(grant_id),
    .arb_busy(arb_busy), .err_timeout(err_timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // UART stand-in: busy rises the cycle after Data_Valid and lasts busy_len cycles
  initial forever begin
    @(negedge clk);
    if (auto_busy && tx_data_valid) begin
      @(posedge clk); #1 tx_busy = 1;
      repeat (busy_len) @(posedge clk);
      #1 tx_busy = 0;
    end
  end
  // behavioural model: phase 0 free, 1 handing off, 2 awaiting busy, 3 awaiting frame end
  int phase = 0, last = N - 1, elapsed = 0;
  logic [N-1:0] m_ack = '0;
  logic m_dv = 0, m_pen = 0, m_ptyp = 0, m_arb = 0, m_err = 0;
  logic [FW-1:0] m_data = '0;
  logic [IW-1:0] m_gid = '0;
  initial forever begin
    @(posedge clk);
    m_ack = '0; m_dv = 0; m_err = 0;
    if (reset) begin
      phase = 0; last = N - 1; m_data = '0; m_pen = 0; m_ptyp = 0; m_gid = '0;
    end else begin
      case (phase)
        0: if (!tx_busy) begin
          for (int off = 1; off <= N; off++) begin
            int k;
            k = (last + off) % N;
            if (phase == 0 && req[k]) begin
              phase = 1; last = k; m_ack[k] = 1; m_dv = 1;
              m_data = req_data[k*FW +: FW]; m_pen = req_par_en[k]; m_ptyp = req_par_typ[k];
              m_gid = IW'(k);
            end
          end
        end
        1: begin phase = 2; elapsed = 1; end
        2: begin
          if (tx_busy) phase = 3;
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (elapsed == TO - 1) begin phase = 0; m_err = 1; end
          else elapsed++;
`endif
        end
        default: if (!tx_busy) phase = 0;
      endcase
    end
    m_arb = phase != 0;
  end
  // compare every cycle once reset has been applied
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("ack", ack, m_ack);
      chk("data_valid", tx_data_valid, m_dv);
      chk("p_data", tx_p_data, m_data);
      chk("par_en", tx_par_en, m_pen);
      chk("par_typ", tx_par_typ, m_ptyp);
      chk("grant_id", grant_id, m_gid);
      chk("arb_busy", arb_busy, m_arb);
      chk("err_timeout", err_timeout, m_err);
      chk("ack_onehot", $countones(ack) <= 1, 1);
    end
  end
  task automatic wait_ack(string name, output int gid);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ack != 0) begin gid = int'(grant_id); return; end
    end
    gid = -1; checks++; errors++;
    $display("FAIL %s: no ack within 200 cycles, required an ack", name);
  endtask
  task automatic wait_idle(string name);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!arb_busy && !tx_busy) return;
    end
    checks++; errors++;
    $display("FAIL %s: arbiter still busy after 200 cycles, required idle", name);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int g, dvs, n;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    @(posedge clk); #1 started = 1;
    @(negedge clk); @(negedge clk);
    chk("rst_dv", tx_data_valid, 0); chk("rst_ack", ack, 0);
    chk("rst_arb_busy", arb_busy, 0); chk("rst_gid", grant_id, 0);
    reset = 0;
    // single requester, one-cycle latency
    auto_busy = 1; req = 4'b0001; req_data[7:0] = 8'hA5; req_par_en = 4'b0001; req_par_typ = 4'b0000;
    @(negedge clk);
    chk("t1_dv", tx_data_valid, 1); chk("t1_data", tx_p_data, 8'hA5); chk("t1_ack", ack, 4'b0001);
    chk("t1_gid", grant_id, 0); chk("t1_par_en", tx_par_en, 1); chk("t1_par_typ", tx_par_typ, PAR_EVEN);
    req = '0;
    wait_idle("t1_idle");
    // all requesters held: fair rotation from requester 0 after reset
    reset = 1; @(negedge clk); reset = 0;
    req_data = 32'h13121110; req_par_en = '0; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack("t2_ack", g);
      chk("t2_order", g, exp_order[i]);
      chk("t2_data", tx_p_data, 8'h10 + exp_order[i]);
    end
    req = '0;
    wait_idle("t2_idle");
    // per-requester parity: 1 enabled/odd, 2 disabled
    req_par_en = 4'b0010; req_par_typ = 4'b0010; req = 4'b0110;
    wait_ack("t3_ack1", g);
    chk("t3_gid1", g, 1); chk("t3_pen1", tx_par_en, 1); chk("t3_ptyp1", tx_par_typ, PAR_ODD);
    req = 4'b0100;
    wait_ack("t3_ack2", g);
    chk("t3_gid2", g, 2); chk("t3_pen2", tx_par_en, 0); chk("t3_ptyp2", tx_par_typ, PAR_EVEN);
    req = '0;
    repeat (4) @(negedge clk);
    chk("t3_busy_hold_pen", tx_par_en, 0); chk("t3_busy_hold_data", tx_p_data, 8'h12);
    wait_idle("t3_idle");
    // UART busy in IDLE blocks the grant
    auto_busy = 0; tx_busy = 1; req = 4'b0001;
    dvs = 0;
    repeat (6) begin @(negedge clk); dvs += int'(tx_data_valid); end
    chk("t4_no_dv", dvs, 0);
    tx_busy = 0;
    @(negedge clk);
    chk("t4_dv", tx_data_valid, 1); chk("t4_gid", grant_id, 0);
    req = '0;
    @(negedge clk); tx_busy = 1;
    repeat (3) @(negedge clk);
    tx_busy = 0; auto_busy = 1;
    wait_idle("t4_idle");
    // reset while waiting for the frame to finish
    req = 4'b1000;
    wait_ack("t5_ack", g);
    chk("t5_gid", g, 3);
    req = '0;
    repeat (4) @(negedge clk);
    chk("t5_in_wait_done", arb_busy, 1);
    reset = 1;
    @(negedge clk);
    chk("t5_rst_dv", tx_data_valid, 0); chk("t5_rst_data", tx_p_data, 0); chk("t5_rst_gid", grant_id, 0);
    chk("t5_rst_arb", arb_busy, 0); chk("t5_rst_pen", tx_par_en, 0); chk("t5_rst_ack", ack, 0);
    reset = 0; req = 4'b1111;
    wait_ack("t5_ack2", g);
    chk("t5_gid_after_rst", g, 0);
    req = '0;
    wait_idle("t5_idle");
`ifdef UART_TX_ARB_TIMEOUT_EN
    // UART never raises busy
    auto_busy = 0; req = 4'b0001;
    @(negedge clk);
    chk("t6_dv", tx_data_valid, 1);
    req = '0; n = 0;
    for (int c = 0; c < 40 && !err_timeout; c++) begin @(negedge clk); n++; end
    chk("t6_latency", n, 16); chk("t6_err", err_timeout, 1); chk("t6_idle", arb_busy, 0);
    auto_busy = 1; req = 4'b0010;
    wait_ack("t6_ack", g);
    chk("t6_gid", g, 1);
    req = '0;
    wait_idle("t6_idle");
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
